wb_sram_slave: RTL and testbench

Pipelined Wishbone B4 slave fronting an on-chip single-port SRAM. It sits directly downstream of WB_MASTER and consumes its CYC/STB/WE/SEL/CTI/BTE/ADR/DAT_WR stream, returning ACK, STALL, ERR and read data. It supports classic and incrementing-burst cycles, with a configurable ACK latency and configurable per-access wait states. It serves as the standard memory target for WB_MASTER-based subsystems and benches.

---
 rtl/wb_defs_pkg.sv | 18 +
 rtl/wb_sram_slave_pkg.sv | 16 +
 rtl/wb_sram_slave_if.sv | 27 ++
 rtl/wb_sram_slave_mem.sv | 31 +++
 rtl/wb_sram_slave.sv | 126 ++++++++++++
 tb/tb_wb_sram_slave.sv | 282 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/wb_defs_pkg.sv
// Shared Wishbone B4 definitions: cycle-type and burst-type encodings.
package wb_defs;

   typedef enum logic [2:0] {
      CtiClassic    = 3'b000,
      CtiConstAddr  = 3'b001,
      CtiIncr       = 3'b010,
      CtiEndOfBurst = 3'b111
   } wb_cti_e;

   typedef enum logic [1:0] {
      BteLinear = 2'b00,
      BteWrap4  = 2'b01,
      BteWrap8  = 2'b10,
      BteWrap16 = 2'b11
   } wb_bte_e;

endpackage

// File: rtl/wb_sram_slave_pkg.sv
// Types and helpers local to the Wishbone SRAM slave.
package wb_sram_slave_pkg;
   import wb_defs::*;

   // One in-flight access, travelling from accept to completion.
   typedef struct packed {
      logic valid;
      logic we;
      logic err;
   } wb_tok_t;

   function automatic logic cti_is_incr(input logic [2:0] cti);
      return cti == CtiIncr;
   endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 pipelined bus between WB_MASTER and the SRAM slave.
interface wb_sram_slave_if;
   logic [31:0] WB_ADR_IN;
   logic        WB_CYC_IN;
   logic        WB_STB_IN;
   logic        WB_WE_IN;
   logic [3:0]  WB_SEL_IN;
   logic [2:0]  WB_CTI_IN;
   logic [1:0]  WB_BTE_IN;
   logic [31:0] WB_DAT_WR_IN;
   logic        WB_ACK_OUT;
   logic        WB_STALL_OUT;
   logic        WB_ERR_OUT;
   logic [31:0] WB_DAT_RD_OUT;

   modport master (
      output WB_ADR_IN, WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_SEL_IN, WB_CTI_IN, WB_BTE_IN,
             WB_DAT_WR_IN,
      input  WB_ACK_OUT, WB_STALL_OUT, WB_ERR_OUT, WB_DAT_RD_OUT
   );

   modport slave (
      input  WB_ADR_IN, WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_SEL_IN, WB_CTI_IN, WB_BTE_IN,
             WB_DAT_WR_IN,
      output WB_ACK_OUT, WB_STALL_OUT, WB_ERR_OUT, WB_DAT_RD_OUT
   );
endinterface

// File: rtl/wb_sram_slave_mem.sv
// Single-port 2^ADDR_WIDTH x 32 RAM with byte-lane writes and a registered read port.
module wb_sram_slave_mem #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  CLK,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**ADDR_WIDTH];
   logic [31:0] rdata_q;

   always_ff @(posedge CLK) begin
      if (req_i) begin
         if (we_i) begin
            for (int i = 0; i < 4; i++) begin
               if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone B4 SRAM slave with configurable ACK latency and wait states.
// Define WB_SRAM_SLAVE_ERR_EN to answer out-of-range or SEL=0 accesses with ERR.
module wb_sram_slave
   import wb_sram_slave_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned WAIT_STATES  = 0
) (
   input logic            CLK,
   input logic            RST_ASYNC,
   input logic            RST_SYNC,
   input logic            EN,
   wb_sram_slave_if.slave bus
);

   logic [2:0]  wait_q, wait_d;
   wb_tok_t     tok_q [READ_LATENCY];
   wb_tok_t     tok_d [READ_LATENCY];
   wb_tok_t     tok_out;
   logic        cyc, stb, stall, accept, acc_err, cpl;
   logic [31:0] mem_rdata, out_dat;

   assign cyc    = bus.WB_CYC_IN;
   assign stb    = bus.WB_STB_IN;
   assign stall  = cyc & stb & ((wait_q != 3'd0) | ~EN);
   assign accept = cyc & stb & ~stall & EN;

`ifdef WB_SRAM_SLAVE_ERR_EN
   assign acc_err = (|bus.WB_ADR_IN[31:ADDR_WIDTH+2]) | (bus.WB_SEL_IN == 4'b0000);
   logic unused_bus;
   assign unused_bus = ^{bus.WB_BTE_IN, bus.WB_ADR_IN[1:0]};
`else
   assign acc_err = 1'b0;
   // Upper address bits alias; BTE is always treated as linear.
   logic unused_bus;
   assign unused_bus = ^{bus.WB_BTE_IN, bus.WB_ADR_IN[1:0], bus.WB_ADR_IN[31:ADDR_WIDTH+2]};
`endif

   wb_sram_slave_mem #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .CLK    (CLK),
      .req_i  (accept & ~acc_err),
      .we_i   (bus.WB_WE_IN),
      .be_i   (bus.WB_SEL_IN),
      .addr_i (bus.WB_ADR_IN[ADDR_WIDTH+1:2]),
      .wdata_i(bus.WB_DAT_WR_IN),
      .rdata_o(mem_rdata)
   );

   always_comb begin
      wait_d = wait_q;
      if (RST_SYNC) begin
         wait_d = 3'd0;
      end else if (EN) begin
         if (!cyc)                        wait_d = 3'(WAIT_STATES);
         else if (accept)                 wait_d = cti_is_incr(bus.WB_CTI_IN) ? 3'd0
                                                                              : 3'(WAIT_STATES);
         else if (stb && wait_q != 3'd0) wait_d = wait_q - 3'd1;
      end
   end

   always_comb begin
      tok_d = tok_q;
      if (EN) begin
         tok_d[0] = '{valid: accept, we: bus.WB_WE_IN, err: acc_err};
         for (int i = 1; i < READ_LATENCY; i++) tok_d[i] = tok_q[i-1];
      end
      // Dropping CYC abandons everything still in flight.
      if (!cyc) begin
         for (int i = 0; i < READ_LATENCY; i++) tok_d[i].valid = 1'b0;
      end
      if (RST_SYNC) begin
         for (int i = 0; i < READ_LATENCY; i++) tok_d[i] = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         wait_q <= 3'd0;
         for (int i = 0; i < READ_LATENCY; i++) tok_q[i] <= '0;
      end else begin
         wait_q <= wait_d;
         tok_q  <= tok_d;
      end
   end

   // RAM read register is stage 1; stages 2..READ_LATENCY carry the data alongside the tokens.
   if (READ_LATENCY > 1) begin : g_dat_pipe
      logic [31:0] dat_q [READ_LATENCY-1];
      logic [31:0] dat_d [READ_LATENCY-1];

      always_comb begin
         dat_d = dat_q;
         if (EN) begin
            dat_d[0] = mem_rdata;
            for (int i = 1; i < READ_LATENCY - 1; i++) dat_d[i] = dat_q[i-1];
         end
      end

      always_ff @(posedge CLK or posedge RST_ASYNC) begin
         if (RST_ASYNC) begin
            for (int i = 0; i < READ_LATENCY - 1; i++) dat_q[i] <= 32'h0;
         end else begin
            dat_q <= dat_d;
         end
      end

      assign out_dat = dat_q[READ_LATENCY-2];
   end else begin : g_dat_direct
      assign out_dat = mem_rdata;
   end

   assign tok_out        = tok_q[READ_LATENCY-1];
   assign cpl            = cyc & EN & tok_out.valid;
   assign bus.WB_ACK_OUT = cpl & ~tok_out.err;
`ifdef WB_SRAM_SLAVE_ERR_EN
   assign bus.WB_ERR_OUT = cpl & tok_out.err;
`else
   assign bus.WB_ERR_OUT = 1'b0;
`endif
   assign bus.WB_STALL_OUT  = stall;
   assign bus.WB_DAT_RD_OUT = (cpl & ~tok_out.we & ~tok_out.err) ? out_dat : 32'h0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomized self-checking bench for wb_sram_slave against a queue-based reference model.
module tb_wb_sram_slave;
   import wb_defs::*;

   localparam int unsigned AW     = 10;
   localparam int unsigned RL     = 3;
   localparam int unsigned WS     = 2;
   localparam int unsigned NWORDS = 16;

   logic CLK = 1'b0;
   logic RST_ASYNC, RST_SYNC, EN;

   wb_sram_slave_if bus ();

   wb_sram_slave #(
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(RL),
      .WAIT_STATES (WS)
   ) dut (
      .CLK      (CLK),
      .RST_ASYNC(RST_ASYNC),
      .RST_SYNC (RST_SYNC),
      .EN       (EN),
      .bus      (bus)
   );

   always #5 CLK = ~CLK;

   // Expected completion: age counts enabled edges since accept; visible when age == RL.
   typedef struct {
      int          age;
      logic        we;
      logic        err;
      logic [31:0] data;
   } cpl_t;

   logic [31:0] ref_mem [int];
   cpl_t        cpl_q [$];
   int          wait_ref;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc_n = 0;
   int          last_acc_cyc, last_ack_cyc;
   int          n_ack_seen = 0, n_err_seen = 0, n_stall_seen = 0;
   logic        last_acc;
   logic [31:0] last_ack_dat;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic set_bus(input logic cyc, input logic stb, input logic we, input logic [3:0] sel,
                          input logic [2:0] cti, input logic [31:0] adr, input logic [31:0] dat);
      bus.WB_CYC_IN    = cyc;
      bus.WB_STB_IN    = stb;
      bus.WB_WE_IN     = we;
      bus.WB_SEL_IN    = sel;
      bus.WB_CTI_IN    = cti;
      bus.WB_BTE_IN    = 2'(BteLinear);
      bus.WB_ADR_IN    = adr;
      bus.WB_DAT_WR_IN = dat;
   endtask

   // One clock cycle: compare outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      logic        vis, exp_stall, acc, err;
      logic [31:0] exp_dat, tmp;
      int          word;
      cpl_t        c;
      @(negedge CLK);
      vis       = bus.WB_CYC_IN && EN && cpl_q.size() > 0 && cpl_q[0].age == int'(RL);
      exp_stall = bus.WB_CYC_IN && bus.WB_STB_IN && (wait_ref != 0 || !EN);
      exp_dat   = 32'h0;
      if (vis && !cpl_q[0].we && !cpl_q[0].err) exp_dat = cpl_q[0].data;
      check_eq("stall", 32'(bus.WB_STALL_OUT), 32'(exp_stall));
      check_eq("ack", 32'(bus.WB_ACK_OUT), 32'(vis && !cpl_q[0].err));
      check_eq("err", 32'(bus.WB_ERR_OUT), 32'(vis && cpl_q[0].err));
      check_eq("dat_rd", bus.WB_DAT_RD_OUT, exp_dat);
      if (bus.WB_ACK_OUT === 1'b1) begin
         n_ack_seen++;
         last_ack_cyc = cyc_n;
         last_ack_dat = bus.WB_DAT_RD_OUT;
      end
      if (bus.WB_ERR_OUT === 1'b1)   n_err_seen++;
      if (bus.WB_STALL_OUT === 1'b1) n_stall_seen++;

      acc      = bus.WB_CYC_IN && bus.WB_STB_IN && !exp_stall;
      last_acc = acc;
      if (acc) begin
         word = int'(bus.WB_ADR_IN[AW+1:2]);
`ifdef WB_SRAM_SLAVE_ERR_EN
         err = ((bus.WB_ADR_IN >> (AW + 2)) != 0) || (bus.WB_SEL_IN == 4'b0000);
`else
         err = 1'b0;
`endif
         c.age  = 0;
         c.we   = bus.WB_WE_IN;
         c.err  = err;
         c.data = 32'h0;
         if (!err) begin
            tmp = ref_mem.exists(word) ? ref_mem[word] : 32'hx;
            if (bus.WB_WE_IN) begin
               for (int b = 0; b < 4; b++)
                  if (bus.WB_SEL_IN[b]) tmp[8*b +: 8] = bus.WB_DAT_WR_IN[8*b +: 8];
               ref_mem[word] = tmp;
            end else begin
               c.data = tmp;
            end
         end
         last_acc_cyc = cyc_n;
         cpl_q.push_back(c);
      end

      if (RST_SYNC) begin
         cpl_q.delete();
         wait_ref = 0;
      end else begin
         if (EN) begin
            foreach (cpl_q[i]) cpl_q[i].age = cpl_q[i].age + 1;
            while (cpl_q.size() > 0 && cpl_q[0].age > int'(RL)) void'(cpl_q.pop_front());
            if (!bus.WB_CYC_IN)                      wait_ref = WS;
            else if (acc)                            wait_ref = (bus.WB_CTI_IN == CtiIncr) ? 0 : WS;
            else if (bus.WB_STB_IN && wait_ref != 0) wait_ref--;
         end
         if (!bus.WB_CYC_IN) cpl_q.delete();
      end
      @(posedge CLK);
      cyc_n++;
      #1;
   endtask

   task automatic beat(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [2:0] cti, input logic [31:0] dat);
      set_bus(1'b1, 1'b1, we, sel, cti, adr, dat);
      for (int n = 0; n < 32; n++) begin
         step();
         if (last_acc) break;
      end
      check_eq("accept", 32'(last_acc), 32'd1);
   endtask

   task automatic idle(input int n);
      bus.WB_STB_IN = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int          a0, k0, s0;
      logic [31:0] w0, adr;
      EN        = 1'b1;
      RST_SYNC  = 1'b0;
      RST_ASYNC = 1'b1;
      wait_ref  = 0;
      set_bus(1'b0, 1'b0, 1'b0, 4'h0, 3'(CtiClassic), 32'h0, 32'h0);
      #1;
      check_eq("rst_ack", 32'(bus.WB_ACK_OUT), 32'd0);
      check_eq("rst_err", 32'(bus.WB_ERR_OUT), 32'd0);
      check_eq("rst_stall", 32'(bus.WB_STALL_OUT), 32'd0);
      check_eq("rst_dat", bus.WB_DAT_RD_OUT, 32'h0);
      repeat (2) @(posedge CLK);
      #1;
      RST_ASYNC = 1'b0;
      step();

      // Preload the working window so every later read hits a known word.
      for (int w = 0; w < int'(NWORDS); w++) beat(1'b1, 32'(w * 4), 4'hF, 3'(CtiClassic), $urandom);
      idle(RL + 1);

      beat(1'b1, 32'h10, 4'hF, 3'(CtiClassic), 32'hDEADBEEF);
      a0 = last_acc_cyc;
      idle(RL + 1);
      check_eq("wr_ack_latency", 32'(last_ack_cyc - a0), 32'(RL));
      beat(1'b0, 32'h10, 4'hF, 3'(CtiClassic), 32'h0);
      a0 = last_acc_cyc;
      idle(RL + 1);
      check_eq("rd_ack_latency", 32'(last_ack_cyc - a0), 32'(RL));
      check_eq("rd_full_word", last_ack_dat, 32'hDEADBEEF);

      beat(1'b1, 32'h10, 4'b0010, 3'(CtiClassic), 32'h0000AB00);
      beat(1'b0, 32'h10, 4'b0001, 3'(CtiClassic), 32'h0);
      idle(RL + 1);
      check_eq("rd_lane_merge", last_ack_dat, 32'hDEADABEF);

      // Write then read the same word on consecutive cycles.
      beat(1'b1, 32'h20, 4'hF, 3'(CtiIncr), 32'h5A5A1234);
      a0 = last_acc_cyc;
      beat(1'b0, 32'h20, 4'hF, 3'(CtiEndOfBurst), 32'h0);
      check_eq("raw_back_to_back", 32'(last_acc_cyc - a0), 32'd1);
      idle(RL + 1);
      check_eq("raw_data", last_ack_dat, 32'h5A5A1234);

      // 8-beat incrementing read burst from a fresh cycle.
      set_bus(1'b0, 1'b0, 1'b0, 4'h0, 3'(CtiClassic), 32'h0, 32'h0);
      step();
      s0 = n_stall_seen;
      k0 = n_ack_seen;
      for (int b = 0; b < 8; b++)
         beat(1'b0, 32'(b * 4), 4'hF, (b == 7) ? 3'(CtiEndOfBurst) : 3'(CtiIncr), 32'h0);
      idle(RL + 1);
      check_eq("burst_stalls", 32'(n_stall_seen - s0), 32'(WS));
      check_eq("burst_acks", 32'(n_ack_seen - k0), 32'd8);

      // Abandon a burst after two accepts.
      beat(1'b0, 32'h0, 4'hF, 3'(CtiIncr), 32'h0);
      beat(1'b0, 32'h4, 4'hF, 3'(CtiIncr), 32'h0);
      set_bus(1'b0, 1'b0, 1'b0, 4'h0, 3'(CtiClassic), 32'h0, 32'h0);
      k0 = n_ack_seen;
      repeat (RL + 2) step();
      check_eq("acks_after_cyc_fall", 32'(n_ack_seen - k0), 32'd0);
      beat(1'b0, 32'h10, 4'hF, 3'(CtiClassic), 32'h0);
      idle(RL + 1);
      check_eq("rd_after_abort", last_ack_dat, 32'hDEADABEF);

`ifdef WB_SRAM_SLAVE_ERR_EN
      w0 = ref_mem[0];
      k0 = n_err_seen;
      s0 = n_ack_seen;
      beat(1'b0, 32'h0000_1000, 4'hF, 3'(CtiClassic), 32'h0);
      beat(1'b1, 32'h0000_1000, 4'hF, 3'(CtiClassic), 32'h12345678);
      idle(RL + 1);
      check_eq("err_count", 32'(n_err_seen - k0), 32'd2);
      check_eq("err_no_ack", 32'(n_ack_seen - s0), 32'd0);
      beat(1'b0, 32'h0, 4'hF, 3'(CtiClassic), 32'h0);
      idle(RL + 1);
      check_eq("word0_intact", last_ack_dat, w0);
`endif

      // Asynchronous reset in the middle of a burst.
      beat(1'b0, 32'h0, 4'hF, 3'(CtiIncr), 32'h0);
      beat(1'b0, 32'h4, 4'hF, 3'(CtiIncr), 32'h0);
      RST_ASYNC = 1'b1;
      #1;
      check_eq("arst_ack", 32'(bus.WB_ACK_OUT), 32'd0);
      check_eq("arst_err", 32'(bus.WB_ERR_OUT), 32'd0);
      check_eq("arst_stall", 32'(bus.WB_STALL_OUT), 32'd0);
      cpl_q.delete();
      wait_ref = 0;
      set_bus(1'b0, 1'b0, 1'b0, 4'h0, 3'(CtiClassic), 32'h0, 32'h0);
      #2;
      RST_ASYNC = 1'b0;
      step();
      beat(1'b0, 32'h10, 4'hF, 3'(CtiClassic), 32'h0);
      idle(RL + 1);
      check_eq("rd_after_arst_a", last_ack_dat, 32'hDEADABEF);
      beat(1'b0, 32'h20, 4'hF, 3'(CtiClassic), 32'h0);
      idle(RL + 1);
      check_eq("rd_after_arst_b", last_ack_dat, 32'h5A5A1234);

      // Random traffic, including EN gaps, CYC drops, SEL=0, aliasing and sync resets.
      for (int n = 0; n < 2000; n++) begin
         logic [2:0] cti;
         logic [3:0] sel;
         logic       stb;
         case ($urandom_range(0, 3))
            0:       cti = 3'(CtiClassic);
            1:       cti = 3'(CtiEndOfBurst);
            2:       cti = 3'(CtiConstAddr);
            default: cti = 3'(CtiIncr);
         endcase
         sel = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         adr = 32'($urandom_range(0, NWORDS - 1)) << 2 | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) adr = adr | (32'($urandom) << (AW + 2));
         stb      = $urandom_range(0, 3) != 0;
         RST_SYNC = $urandom_range(0, 63) == 0;
         if (RST_SYNC) stb = 1'b0;
         EN = $urandom_range(0, 7) != 0;
         set_bus($urandom_range(0, 15) != 0, stb, 1'($urandom), sel, cti, adr, $urandom);
         step();
      end
      RST_SYNC = 1'b0;
      EN       = 1'b1;
      idle(RL + 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
